// File: rtl/myproject_udiv_pkg.sv
// rtl/myproject_udiv_pkg.sv - shared types and widths for the sequential unsigned divider
package myproject_udiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } udiv_state_t;

    localparam int UDIV_DIN0_WIDTH = 9;
    localparam int UDIV_DIN1_WIDTH = 7;
    localparam int UDIV_DOUT_WIDTH = 9;

    // Iteration counter must hold N-1; never narrower than one bit.
    function automatic int udiv_cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int UDIV_CNT_WIDTH = udiv_cnt_width(UDIV_DIN0_WIDTH);

endpackage

// File: rtl/myproject_udiv_step.sv
// rtl/myproject_udiv_step.sv - one combinational radix-2 restoring division step
module myproject_udiv_step #(
    parameter int M = 7
) (
    input  logic [M-1:0] i_r,
    input  logic         i_q_msb,
    input  logic [M-1:0] i_d,
    output logic [M-1:0] o_r_next,
    output logic         o_qbit
);

    logic [M:0] w_t;
    logic [M:0] w_diff;

    // Shifted partial remainder is M+1 bits; the extra bit only matters for the compare.
    assign w_t    = {i_r, i_q_msb};
    assign w_diff = w_t - {1'b0, i_d};

    // With i_r < i_d, T < 2*D, so the top bit of T-D is clear exactly when T >= D.
    assign o_qbit   = ~w_diff[M];
    assign o_r_next = o_qbit ? w_diff[M-1:0] : w_t[M-1:0];

endmodule

// File: rtl/myproject_udiv_9ns_7ns_seq.sv
// rtl/myproject_udiv_9ns_7ns_seq.sv - sequential unsigned divider, one quotient bit per clock
module myproject_udiv_9ns_7ns_seq
    import myproject_udiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = UDIV_DIN0_WIDTH,
    parameter int din1_WIDTH = UDIV_DIN1_WIDTH,
    parameter int dout_WIDTH = UDIV_DOUT_WIDTH
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [dout_WIDTH-1:0] dout_quot,
    output logic [din1_WIDTH-1:0] dout_rem,
    output logic                  dout_dbz,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int N  = din0_WIDTH;
    localparam int M  = din1_WIDTH;
    localparam int CW = udiv_cnt_width(N);

    // Quotient shares the dividend register, so the two widths must agree.
    if (dout_WIDTH != din0_WIDTH) begin : g_width_check
        $error("udiv instance %0d: dout_WIDTH must equal din0_WIDTH", ID);
    end

    udiv_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [M-1:0]  r_d;
    logic [N-1:0]  r_q;
    logic [M-1:0]  r_r;
    logic [N-1:0]  r_quot;
    logic [M-1:0]  r_rem;
    logic          r_dbz;
    logic          r_out_valid;
    logic          r_in_ready;

    logic [M-1:0]  w_r_next;
    logic          w_qbit;
    logic [N-1:0]  w_q_next;

    myproject_udiv_step #(
        .M (M)
    ) u_step (
        .i_r      (r_r),
        .i_q_msb  (r_q[N-1]),
        .i_d      (r_d),
        .o_r_next (w_r_next),
        .o_qbit   (w_qbit)
    );

    assign w_q_next = {r_q[N-2:0], w_qbit};

    // Control FSM and datapath: accept in IDLE, iterate N steps in BUSY, hold result in DONE.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_d         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        if (din1 != '0) begin
                            r_d     <= din1;
                            r_q     <= din0;
                            r_r     <= '0;
                            r_cnt   <= CW'(N - 1);
                            r_state <= ST_BUSY;
                        end else begin
                            r_quot      <= '1;
                            r_rem       <= '0;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    r_r <= w_r_next;
                    r_q <= w_q_next;
                    if (r_cnt == '0) begin
                        r_quot      <= w_q_next;
                        r_rem       <= w_r_next;
                        r_dbz       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dout_quot = r_quot;
    assign dout_rem  = r_rem;
    assign dout_dbz  = r_dbz;

endmodule
